// File: rtl/yarp_pkg.sv
// Shared types for the yarp memory-side blocks: arbiter FSM states, owner
// encoding and the load/store byte-enable codes.
package yarp_pkg;

    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b11;

    localparam int ARB_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } mem_arb_state_e;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } mem_owner_e;

    // One-hot winner bit positions produced by yarp_mem_arb_sel
    localparam int WIN_IMEM = 0;
    localparam int WIN_DMEM = 1;

endpackage

// File: rtl/yarp_mem_arb_sel.sv
// Two-way request selector: a lone request always wins; on a collision the
// pointer names the favoured requester. Output is one-hot (or zero).
module yarp_mem_arb_sel
    import yarp_pkg::*;
(
    input  logic       imem_req_i,
    input  logic       dmem_req_i,
    input  mem_owner_e ptr_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = 2'b00;
        if (imem_req_i && dmem_req_i) begin
            if (ptr_i == OWN_DMEM) win_o[WIN_DMEM] = 1'b1;
            else                   win_o[WIN_IMEM] = 1'b1;
        end else if (dmem_req_i) begin
            win_o[WIN_DMEM] = 1'b1;
        end else if (imem_req_i) begin
            win_o[WIN_IMEM] = 1'b1;
        end
    end

endmodule

// File: rtl/yarp_mem_arb.sv
// Fetch/data arbiter onto a single memory port, one transaction in flight.
// Define YARP_MEM_ARB_RR_EN for round-robin collisions; otherwise data wins.
module yarp_mem_arb
    import yarp_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        imem_req_i,
    input  logic [31:0] imem_addr_i,
    output logic        imem_gnt_o,
    output logic        imem_rvalid_o,
    output logic [31:0] imem_rdata_o,

    input  logic        dmem_req_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [1:0]  dmem_byte_en_i,
    input  logic        dmem_wr_i,
    input  logic [31:0] dmem_wr_data_i,
    output logic        dmem_gnt_o,
    output logic        dmem_rvalid_o,
    output logic [31:0] dmem_rdata_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [1:0]  mem_byte_en_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        err_o
);

    localparam logic [ARB_CNT_W-1:0] TMO = ARB_CNT_W'(RSP_TIMEOUT);

    mem_arb_state_e       state_q, state_d;
    mem_owner_e           owner_q, owner_d;
    logic [31:0]          addr_q, addr_d;
    logic [1:0]           be_q, be_d;
    logic                 wr_q, wr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]           win;
    logic                 timeout;
    mem_owner_e           sel_ptr;

`ifdef YARP_MEM_ARB_RR_EN
    mem_owner_e ptr_q, ptr_d;
    assign sel_ptr = ptr_q;
`else
    assign sel_ptr = OWN_DMEM;
`endif

    yarp_mem_arb_sel u_sel (
        .imem_req_i (imem_req_i),
        .dmem_req_i (dmem_req_i),
        .ptr_i      (sel_ptr),
        .win_o      (win)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
`ifdef YARP_MEM_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win[WIN_DMEM]) begin
                    state_d = ISSUE;
                    owner_d = OWN_DMEM;
                    addr_d  = dmem_addr_i;
                    be_d    = dmem_byte_en_i;
                    wr_d    = dmem_wr_i;
                    wdata_d = dmem_wr_data_i;
                end else if (win[WIN_IMEM]) begin
                    state_d = ISSUE;
                    owner_d = OWN_IMEM;
                    addr_d  = imem_addr_i;
                    be_d    = WORD;
                    wr_d    = 1'b0;
                    wdata_d = '0;
                end
            end
            ISSUE: begin
                if (mem_gnt_i) begin
                    state_d = WAIT_RSP;
                    cnt_d   = '0;
`ifdef YARP_MEM_ARB_RR_EN
                    ptr_d   = (owner_q == OWN_DMEM) ? OWN_IMEM : OWN_DMEM;
`endif
                end
            end
            WAIT_RSP: begin
                // A real response in the timeout cycle still counts as a response
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end else if (cnt_q == TMO) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_IMEM;
            addr_q  <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
`ifdef YARP_MEM_ARB_RR_EN
            ptr_q   <= OWN_DMEM;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
`ifdef YARP_MEM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Handshake outputs are masked during reset so an abandoned
    // transaction never reports a response or an error.
    logic        in_issue, in_wait, rsp_vld, own_d;
    logic [31:0] rsp_data;

    assign in_issue = (state_q == ISSUE) && !reset;
    assign in_wait  = (state_q == WAIT_RSP) && !reset;
    assign own_d    = (owner_q == OWN_DMEM);
    assign rsp_vld  = in_wait && (mem_rvalid_i || timeout);
    assign rsp_data = (in_wait && !timeout) ? mem_rdata_i : '0;

    assign mem_req_o     = in_issue;
    assign mem_addr_o    = addr_q;
    assign mem_byte_en_o = be_q;
    assign mem_wr_o      = wr_q;
    assign mem_wr_data_o = wdata_q;

    assign imem_gnt_o    = in_issue && !own_d && mem_gnt_i;
    assign dmem_gnt_o    = in_issue &&  own_d && mem_gnt_i;
    assign imem_rvalid_o = rsp_vld && !own_d;
    assign dmem_rvalid_o = rsp_vld &&  own_d;
    assign imem_rdata_o  = own_d ? '0 : rsp_data;
    assign dmem_rdata_o  = own_d ? rsp_data : '0;
    assign err_o         = in_wait && timeout;

endmodule

// File: tb/tb_yarp_mem_arb.sv
// Directed bench for yarp_mem_arb (RSP_TIMEOUT=4); expectations follow the
// build's collision policy via YARP_MEM_ARB_RR_EN.
module tb_yarp_mem_arb;
    import yarp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_i, dmem_req_i, dmem_wr_i;
    logic [31:0] imem_addr_i, dmem_addr_i, dmem_wr_data_i, mem_rdata_i;
    logic [1:0]  dmem_byte_en_i;
    logic        mem_gnt_i, mem_rvalid_i;
    logic        imem_gnt_o, imem_rvalid_o, dmem_gnt_o, dmem_rvalid_o;
    logic [31:0] imem_rdata_o, dmem_rdata_o, mem_addr_o, mem_wr_data_o;
    logic        mem_req_o, mem_wr_o, err_o;
    logic [1:0]  mem_byte_en_o;

    int n_chk  = 0;
    int n_fail = 0;

    yarp_mem_arb #(.RSP_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_gnt_o(imem_gnt_o),
        .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
        .dmem_req_i(dmem_req_i), .dmem_addr_i(dmem_addr_i), .dmem_byte_en_i(dmem_byte_en_i),
        .dmem_wr_i(dmem_wr_i), .dmem_wr_data_i(dmem_wr_data_i), .dmem_gnt_o(dmem_gnt_o),
        .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_byte_en_o(mem_byte_en_o),
        .mem_wr_o(mem_wr_o), .mem_wr_data_o(mem_wr_data_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {23'd0, mem_req_o, mem_wr_o, mem_byte_en_o, imem_gnt_o,
                            dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o, err_o}, 32'd0);
        chk({tag, "_dat"}, mem_addr_o | mem_wr_data_o | imem_rdata_o | dmem_rdata_o, 32'd0);
    endtask

    // Capture edge, ISSUE with immediate grant, one-cycle response.
    task automatic serve(input bit exp_dmem, input logic [31:0] exp_addr,
                         input logic [1:0] exp_be, input logic [31:0] rdata,
                         input bit rearm, input string tag);
        step;
        chk({tag, "_req"}, {31'd0, mem_req_o}, 32'd1);
        chk({tag, "_addr"}, mem_addr_o, exp_addr);
        chk({tag, "_be"}, {30'd0, mem_byte_en_o}, {30'd0, exp_be});
        mem_gnt_i = 1'b1;
        #1;
        chk({tag, "_gnt"}, {30'd0, dmem_gnt_o, imem_gnt_o}, exp_dmem ? 32'd2 : 32'd1);
        step;
        mem_gnt_i = 1'b0;
        if (!rearm) begin
            if (exp_dmem) dmem_req_i = 1'b0;
            else          imem_req_i = 1'b0;
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        #1;
        chk({tag, "_rvld"}, {30'd0, dmem_rvalid_o, imem_rvalid_o}, exp_dmem ? 32'd2 : 32'd1);
        chk({tag, "_rdata"}, exp_dmem ? dmem_rdata_o : imem_rdata_o, rdata);
        chk({tag, "_other"}, exp_dmem ? imem_rdata_o : dmem_rdata_o, 32'd0);
        chk({tag, "_reqlo"}, {31'd0, mem_req_o}, 32'd0);
        step;
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        imem_req_i = 0; imem_addr_i = 0;
        dmem_req_i = 0; dmem_addr_i = 0; dmem_byte_en_i = 0; dmem_wr_i = 0; dmem_wr_data_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        step;
        step;
        chk_quiet("reset");
        reset = 1'b0;
        #1;

        // Single fetch
        imem_req_i = 1'b1; imem_addr_i = 32'h100;
        serve(1'b0, 32'h100, WORD, 32'hDEADBEEF, 1'b0, "fetch");

        // Collision: data first, then the fetch still waiting
        imem_req_i = 1'b1; imem_addr_i = 32'h200;
        dmem_req_i = 1'b1; dmem_addr_i = 32'h300; dmem_byte_en_i = HALF_WORD;
        dmem_wr_i = 1'b1; dmem_wr_data_i = 32'h55;
        step;
        chk("col_wr", {31'd0, mem_wr_o}, 32'd1);
        chk("col_wdata", mem_wr_data_o, 32'h55);
        mem_gnt_i = 1'b1;
        #1;
        chk("col_d_gnt", {30'd0, dmem_gnt_o, imem_gnt_o}, 32'd2);
        step;
        mem_gnt_i = 1'b0; dmem_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
        #1;
        chk("col_d_rvld", {30'd0, dmem_rvalid_o, imem_rvalid_o}, 32'd2);
        step;
        mem_rvalid_i = 1'b0;
        serve(1'b0, 32'h200, WORD, 32'h1111_2222, 1'b0, "col_i");

        // Back-to-back colliding pairs
        imem_req_i = 1'b1; dmem_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef YARP_MEM_ARB_RR_EN
            bit exp_d = (i % 2 == 0);
`else
            bit exp_d = 1'b1;
`endif
            serve(exp_d, exp_d ? 32'h300 : 32'h200, exp_d ? HALF_WORD : WORD,
                  32'hC0DE_0000 + 32'(i), 1'b1, $sformatf("pair%0d", i));
        end
        imem_req_i = 1'b0; dmem_req_i = 1'b0;

        // Stalled grant; late attribute changes must not leak through
        dmem_req_i = 1'b1; dmem_addr_i = 32'h400; dmem_byte_en_i = BYTE;
        dmem_wr_i = 1'b1; dmem_wr_data_i = 32'hA5A5;
        step;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_req", i), {31'd0, mem_req_o}, 32'd1);
            chk($sformatf("stall%0d_addr", i), mem_addr_o, 32'h400);
            chk($sformatf("stall%0d_wd", i), mem_wr_data_o, 32'hA5A5);
            chk($sformatf("stall%0d_gnt", i), {30'd0, dmem_gnt_o, imem_gnt_o}, 32'd0);
            if (i == 1) begin dmem_addr_i = 32'h999; dmem_wr_data_i = 32'h0; end
            step;
        end
        mem_gnt_i = 1'b1;
        #1;
        chk("stall_gnt", {30'd0, dmem_gnt_o, imem_gnt_o}, 32'd2);
        step;
        mem_gnt_i = 1'b0; dmem_req_i = 1'b0; dmem_wr_i = 1'b0; mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h0;
        #1;
        chk("stall_rvld", {31'd0, dmem_rvalid_o}, 32'd1);
        step;
        mem_rvalid_i = 1'b0;

        // Response timeout with RSP_TIMEOUT=4: fires in the fifth WAIT_RSP cycle
        imem_req_i = 1'b1; imem_addr_i = 32'h500; mem_rdata_i = 32'hFFFF_FFFF;
        step;
        mem_gnt_i = 1'b1;
        step;
        mem_gnt_i = 1'b0; imem_req_i = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tmo_w%0d", i), {30'd0, err_o, imem_rvalid_o}, 32'd0);
            step;
        end
        chk("tmo_err", {31'd0, err_o}, 32'd1);
        chk("tmo_rvld", {30'd0, dmem_rvalid_o, imem_rvalid_o}, 32'd1);
        chk("tmo_rdata", imem_rdata_o, 32'd0);
        step;
        chk("tmo_err_once", {31'd0, err_o}, 32'd0);
        mem_rvalid_i = 1'b1;
        #1;
        chk("tmo_late", {30'd0, err_o, imem_rvalid_o}, 32'd0);
        step;
        chk("tmo_late2", {29'd0, mem_req_o, err_o, imem_rvalid_o}, 32'd0);
        mem_rvalid_i = 1'b0;

        // Reset while waiting for a response
        dmem_req_i = 1'b1; dmem_addr_i = 32'h600; dmem_byte_en_i = WORD; dmem_wr_i = 1'b1;
        dmem_wr_data_i = 32'h77;
        step;
        mem_gnt_i = 1'b1;
        step;
        mem_gnt_i = 1'b0; dmem_req_i = 1'b0; dmem_wr_i = 1'b0;
        reset = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234;
        #1;
        chk("rstw_rvld", {30'd0, err_o, dmem_rvalid_o}, 32'd0);
        step;
        reset = 1'b0;
        #1;
        chk_quiet("rstw_post");
        step;
        chk_quiet("rstw_post2");
        mem_rvalid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/yarp_mem_arb.md
YARP_MEM_ARB -- requirements
Module: yarp_mem_arb

Interface
REQ-001 The block SHALL have one parameter: RSP_TIMEOUT, default 255, the maximum number of WAIT_RSP cycles before an aborted response.
REQ-002 The block SHALL use one clock, clk, and a synchronous, active-high reset named reset; the polarity and synchronicity are fixed.
REQ-003 The ports SHALL be, clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- imem_req_i  in  1  instruction fetch request
- imem_addr_i  in  32  fetch address
- imem_gnt_o  out  1  fetch grant
- imem_rvalid_o  out  1  fetch response valid
- imem_rdata_o  out  32  fetch response data
- dmem_req_i  in  1  data request
- dmem_addr_i  in  32  data address
- dmem_byte_en_i  in  2  BYTE, HALF_WORD or WORD
- dmem_wr_i  in  1  1 = write
- dmem_wr_data_i  in  32  write data
- dmem_gnt_o  out  1  data grant
- dmem_rvalid_o  out  1  data response valid
- dmem_rdata_o  out  32  data response data
- mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o  out  1/32/2/1/32  shared memory port
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory read data
- err_o  out  1  one-cycle response-timeout pulse

Function
REQ-004 The block SHALL share one memory port between the fetch requester and the data requester, with one transaction outstanding at a time.
REQ-005 The FSM SHALL have three states, IDLE, ISSUE and WAIT_RSP, with these transitions:
- IDLE to ISSUE when any request is high.
- ISSUE to WAIT_RSP when mem_gnt_i is high.
- WAIT_RSP to IDLE on mem_rvalid_i or on timeout.
REQ-006 In IDLE with a request, the block SHALL register the winner (owner) and its attributes; mem_req_o SHALL rise on the next cycle.
REQ-007 Fetch attributes SHALL be: byte_en WORD, wr 0, wr_data 0.
REQ-008 In ISSUE, mem_req_o SHALL be 1 and mem_addr_o, mem_byte_en_o, mem_wr_o and mem_wr_data_o SHALL hold the registered values.
REQ-009 While in ISSUE, the owner's gnt_o SHALL equal mem_gnt_i combinationally; the other requester's gnt_o SHALL stay 0.
REQ-010 On leaving ISSUE, mem_req_o SHALL be 0 on the following cycle.
REQ-011 Requesters SHALL hold req and attributes stable until gnt; the block SHALL ignore attribute changes after capture.
REQ-012 In WAIT_RSP, the owner's rvalid_o SHALL equal mem_rvalid_i and its rdata_o SHALL equal mem_rdata_i, both combinationally.
REQ-013 The non-owner's rvalid_o SHALL be 0 and its rdata_o SHALL be 0 at all times.
REQ-014 Memory SHALL return one rvalid per granted transaction, writes included, no earlier than the cycle after gnt.
REQ-015 mem_rvalid_i outside WAIT_RSP SHALL be ignored.
REQ-016 A 16-bit counter SHALL clear on entry to WAIT_RSP and increment each WAIT_RSP cycle without rvalid.
REQ-017 When the counter equals RSP_TIMEOUT, the block SHALL:
- assert the owner's rvalid_o with rdata 0;
- pulse err_o for one cycle;
- return to IDLE.
REQ-018 Minimum latency SHALL be: request captured at cycle 0, mem_req_o at cycle 1, gnt at the earliest cycle 1, rvalid_o at the earliest cycle 2.
REQ-019 After WAIT_RSP the block SHALL spend at least one cycle in IDLE, giving a peak rate of one transaction per 3 cycles.
REQ-020 Arbitration on simultaneous requests SHALL follow REQ-024 and REQ-025; a single request SHALL always win.

Reset
REQ-021 On reset: state IDLE; all outputs 0; counter 0; owner and registered attributes 0; round-robin pointer set to data.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction without asserting rvalid_o or err_o.
REQ-023 A mem_rvalid_i arriving after reset SHALL be ignored.

Configuration
REQ-024 With YARP_MEM_ARB_RR_EN defined, simultaneous requests SHALL be resolved round-robin: the pointer favours the requester not served last and updates on each grant.
REQ-025 Without YARP_MEM_ARB_RR_EN, the data requester SHALL always win simultaneous requests, and no pointer SHALL exist.

Structure
REQ-026 The state enum and the owner encoding (OWN_IMEM, OWN_DMEM) SHALL live in yarp_pkg, reusing the existing BYTE, HALF_WORD and WORD byte-enable constants.
REQ-027 The round-robin/priority choice SHALL be a sub-module, yarp_mem_arb_sel (inputs: two requests and the pointer; output: the one-hot winner).
REQ-028 The FSM, capture registers and timeout counter SHALL remain in yarp_mem_arb.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Single fetch: imem_req=1, addr 0x100; gnt at cycle 1; rvalid with rdata 0xDEADBEEF at cycle 2 -> imem_gnt_o=1 at cycle 1, imem_rdata_o=0xDEADBEEF at cycle 2, mem_byte_en_o=WORD.
- Collision, fixed priority: both requests at cycle 0 -> dmem served first; imem is granted in the next transaction.
- Collision with YARP_MEM_ARB_RR_EN: 4 back-to-back colliding pairs -> owners alternate dmem, imem, dmem, imem.
- Stalled grant: mem_gnt_i=0 for 5 cycles -> mem_req_o and attributes stable; no gnt_o asserted until mem_gnt_i=1.
- Timeout: RSP_TIMEOUT=4, no rvalid -> err_o pulses once; owner rvalid_o=1 with rdata 0; a late mem_rvalid_i is ignored.
- Reset in WAIT_RSP -> next cycle all outputs 0, state IDLE, no rvalid_o.
